i2c_slave_target_fsm: RTL and testbench

Synthesisable I2C target (slave) controller: the DUT-side stage that consumes the bit-level SCL/SDA traffic driven by the I2C master agent. It sits directly downstream of the master driver on the shared open-drain bus. It decodes START/STOP, matches a 7-bit slave address, and ACKs. It accumulates write bytes into one DATA_WIDTH-bit register and serves that register back on reads, MSB first. One instance per slave address; the bench instantiates NO_OF_SLAVES copies with SLAVE0..3_ADDRESS.

---
 rtl/i2c_slave_target_fsm_if.sv | 19 +
 rtl/i2c_slave_target_fsm.sv | 210 +++++++++++++++++++++
 tb/tb_i2c_slave_target_fsm.sv | 334 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/i2c_slave_target_fsm_if.sv
// i2c_slave_target_fsm_if: open-drain I2C pin bundle.
// scl_i/sda_i: bus pin levels; sda_oe: 1 = target pulls SDA low.
interface i2c_slave_target_fsm_if;
  logic scl_i;
  logic sda_i;
  logic sda_oe;

  modport master (
    output scl_i,
    output sda_i,
    input  sda_oe
  );

  modport slave (
    input  scl_i,
    input  sda_i,
    output sda_oe
  );
endinterface

// File: rtl/i2c_slave_target_fsm.sv
// i2c_slave_target_fsm: I2C target with one DATA_WIDTH register.
// Ports: pclk, areset_n, bus (scl_i, sda_i, sda_oe), reg_q,
//        wr_done, rd_done, busy.
module i2c_slave_target_fsm #(
  parameter logic [6:0] SLAVE_ADDRESS = 7'b110_1000,
  parameter int DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic                  pclk,
  input  logic                  areset_n,
  i2c_slave_target_fsm_if.slave bus,
  output logic [DATA_WIDTH-1:0] reg_q,
  output logic                  wr_done,
  output logic                  rd_done,
  output logic                  busy
);

  localparam int BYTES = DATA_WIDTH / 8;
  localparam int IW = $clog2(BYTES + 1);
  localparam logic [IW-1:0] LAST = IW'(BYTES - 1);
  localparam logic [IW-1:0] OVF = IW'(BYTES);

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    ADDR_ACK,
    WR_DATA,
    WR_ACK,
    RD_DATA,
    RD_MACK,
    IGNORE
  } state_t;

  logic scl_s1, scl_s2, scl_d;
  logic sda_s1, sda_s2, sda_d;

  // Reset to the idle bus level so no edge is seen on release.
  always_ff @(posedge pclk or negedge areset_n) begin
    if (!areset_n) begin
      scl_s1 <= 1'b1;
      scl_s2 <= 1'b1;
      scl_d  <= 1'b1;
      sda_s1 <= 1'b1;
      sda_s2 <= 1'b1;
      sda_d  <= 1'b1;
    end else begin
      scl_s1 <= bus.scl_i;
      scl_s2 <= scl_s1;
      scl_d  <= scl_s2;
      sda_s1 <= bus.sda_i;
      sda_s2 <= sda_s1;
      sda_d  <= sda_s2;
    end
  end

  logic scl_rise, scl_fall;
  logic start_det, stop_det;

  assign scl_rise  = scl_s2 & ~scl_d;
  assign scl_fall  = ~scl_s2 & scl_d;
  assign start_det = scl_s2 & scl_d
                   & sda_d & ~sda_s2;
  assign stop_det  = scl_s2 & scl_d
                   & ~sda_d & sda_s2;

  state_t                state;
  logic [3:0]            cnt;
  logic [7:0]            sh;
  logic                  rw;
  logic [IW-1:0]         idx;
  logic [DATA_WIDTH-1:0] stage;
  logic [DATA_WIDTH-1:0] snap;
  logic [DATA_WIDTH-1:0] snap_rot;

  // Read snapshot rotates left a byte per master ACK, so the
  // top byte is always the next one out and wrap is free.
  assign snap_rot = (snap << 8)
                  | (snap >> (DATA_WIDTH - 8));

  always_ff @(posedge pclk or negedge areset_n) begin
    if (!areset_n) begin
      state      <= IDLE;
      cnt        <= '0;
      sh         <= '0;
      rw         <= 1'b0;
      idx        <= '0;
      stage      <= '0;
      snap       <= '0;
      reg_q      <= RESET_VALUE;
      bus.sda_oe <= 1'b0;
      wr_done    <= 1'b0;
      rd_done    <= 1'b0;
      busy       <= 1'b0;
    end else begin
      wr_done <= 1'b0;
      rd_done <= 1'b0;
      if (stop_det) begin
        state      <= IDLE;
        cnt        <= '0;
        stage      <= '0;
        bus.sda_oe <= 1'b0;
        busy       <= 1'b0;
      end else if (start_det) begin
        state      <= ADDR;
        cnt        <= '0;
        stage      <= '0;
        bus.sda_oe <= 1'b0;
        busy       <= 1'b0;
      end else begin
        unique case (state)
          IDLE: begin
          end
          ADDR: begin
            if (scl_rise) begin
              sh  <= {sh[6:0], sda_s2};
              cnt <= cnt + 4'd1;
            end else if (scl_fall && cnt == 4'd8) begin
              cnt <= '0;
              rw  <= sh[0];
              if (sh[7:1] == SLAVE_ADDRESS) begin
                state      <= ADDR_ACK;
                bus.sda_oe <= 1'b1;
                busy       <= 1'b1;
              end else begin
                state <= IGNORE;
              end
            end
          end
          ADDR_ACK: begin
            if (scl_fall) begin
              cnt <= '0;
              if (rw) begin
                snap       <= reg_q;
                sh         <= reg_q[DATA_WIDTH-1 -: 8];
                bus.sda_oe <= ~reg_q[DATA_WIDTH-1];
                state      <= RD_DATA;
              end else begin
                bus.sda_oe <= 1'b0;
                idx        <= '0;
                state      <= WR_DATA;
              end
            end
          end
          WR_DATA: begin
            if (scl_rise) begin
              sh  <= {sh[6:0], sda_s2};
              cnt <= cnt + 4'd1;
            end else if (scl_fall && cnt == 4'd8) begin
              cnt <= '0;
              if (idx == OVF) begin
                // Overflow byte: leaving SDA released is the NACK.
                state <= IGNORE;
              end else begin
                stage <= (stage << 8)
                       | DATA_WIDTH'(sh);
                bus.sda_oe <= 1'b1;
                state      <= WR_ACK;
              end
            end
          end
          WR_ACK: begin
            if (scl_rise && idx == LAST) begin
              reg_q   <= stage;
              wr_done <= 1'b1;
            end else if (scl_fall) begin
              bus.sda_oe <= 1'b0;
              idx        <= idx + IW'(1);
              state      <= WR_DATA;
            end
          end
          RD_DATA: begin
            if (scl_rise) begin
              cnt <= cnt + 4'd1;
            end else if (scl_fall) begin
              if (cnt == 4'd8) begin
                cnt        <= '0;
                bus.sda_oe <= 1'b0;
                state      <= RD_MACK;
              end else begin
                sh         <= {sh[6:0], 1'b0};
                bus.sda_oe <= ~sh[6];
              end
            end
          end
          RD_MACK: begin
            if (scl_rise) begin
              if (sda_s2) begin
                rd_done <= 1'b1;
                state   <= IGNORE;
              end else begin
                snap <= snap_rot;
                sh   <= snap_rot[DATA_WIDTH-1 -: 8];
              end
            end else if (scl_fall) begin
              cnt        <= '0;
              bus.sda_oe <= ~sh[7];
              state      <= RD_DATA;
            end
          end
          IGNORE: begin
          end
          default: begin
            state <= IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_i2c_slave_target_fsm.sv
// tb_i2c_slave_target_fsm: scoreboard bench for the I2C target.
// A bit-level master drives the bus; a monitor checks the DUT.
module tb_i2c_slave_target_fsm;

  localparam logic [6:0] SA = 7'h68;
  localparam int BYTES = 4;

  logic        pclk = 1'b0;
  logic        areset_n = 1'b0;
  logic        scl = 1'b1;
  logic        sda_m = 1'b1;
  logic [31:0] reg_q;
  logic        wr_done, rd_done, busy;

  i2c_slave_target_fsm_if bus_if ();

  assign bus_if.scl_i = scl;
  assign bus_if.sda_i = sda_m & ~bus_if.sda_oe;

  i2c_slave_target_fsm #(
    .SLAVE_ADDRESS(SA),
    .DATA_WIDTH(32),
    .RESET_VALUE(32'h0)
  ) dut (
    .pclk(pclk),
    .areset_n(areset_n),
    .bus(bus_if.slave),
    .reg_q(reg_q),
    .wr_done(wr_done),
    .rd_done(rd_done),
    .busy(busy)
  );

  always #5 pclk = ~pclk;

  typedef struct {
    string       tag;
    int unsigned val;
  } item_t;

  item_t       exp_q[$];
  item_t       obs_q[$];
  logic [31:0] exp_wr[$];
  logic [31:0] mdl_reg;
  logic [7:0]  wbuf[0:15];
  int          checks = 0;
  int          errors = 0;
  int          wr_seen = 0;
  int          rd_seen = 0;
  int          wr_exp = 0;
  int          rd_exp = 0;
  int          quiet_hits = 0;
  logic        quiet = 1'b0;
  item_t       mo, me;
  logic [31:0] mw;

  function automatic void push_exp(string t, int unsigned v);
    item_t it;
    it.tag = t;
    it.val = v;
    exp_q.push_back(it);
  endfunction

  function automatic void push_obs(string t, int unsigned v);
    item_t it;
    it.tag = t;
    it.val = v;
    obs_q.push_back(it);
  endfunction

  task automatic check(string n, int unsigned got, int unsigned want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", n, got, want);
    end
  endtask

  // Monitor: compares observed items and DUT pulses to the model.
  always @(negedge pclk) begin
    if (obs_q.size() > 0) begin
      mo = obs_q.pop_front();
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL %s: got %0h, nothing expected",
                 mo.tag, mo.val);
      end else begin
        me = exp_q.pop_front();
        if (mo.tag != me.tag || mo.val != me.val) begin
          errors++;
          $display("FAIL %s: got %0h, expected %s=%0h",
                   mo.tag, mo.val, me.tag, me.val);
        end
      end
    end
    if (wr_done) begin
      wr_seen++;
      checks++;
      if (exp_wr.size() == 0) begin
        errors++;
        $display("FAIL wr_done: unexpected, reg_q %h", reg_q);
      end else begin
        mw = exp_wr.pop_front();
        if (reg_q !== mw) begin
          errors++;
          $display("FAIL commit: reg_q %h, expected %h", reg_q, mw);
        end
      end
    end
    if (rd_done) rd_seen++;
    if (quiet && (bus_if.sda_oe || busy)) quiet_hits++;
  end

  // ---------------- reference model ----------------
  function automatic logic [7:0] mbyte(int i);
    return mdl_reg[8*(BYTES-1-(i % BYTES)) +: 8];
  endfunction

  function automatic void model_write(logic [6:0] a, int n, bit stp);
    push_exp("aack", (a == SA) ? 0 : 1);
    if (a == SA) begin
      push_exp("busy", 1);
      for (int i = 0; i < n && i <= BYTES; i++)
        push_exp("wack", (i < BYTES) ? 0 : 1);
      if (n >= BYTES) begin
        mdl_reg = {wbuf[0], wbuf[1], wbuf[2], wbuf[3]};
        exp_wr.push_back(mdl_reg);
        wr_exp++;
      end
    end
    if (stp) begin
      if (a != SA) push_exp("quiet", 0);
      push_exp("idle_busy", 0);
    end
  endfunction

  function automatic void model_read(logic [6:0] a, int n);
    push_exp("aack", (a == SA) ? 0 : 1);
    if (a == SA) begin
      push_exp("busy", 1);
      for (int i = 0; i < n; i++) push_exp("rdata", mbyte(i));
      rd_exp++;
    end
    if (a != SA) push_exp("quiet", 0);
    push_exp("idle_busy", 0);
  endfunction

  // ---------------- bit-level master ----------------
  task automatic bit_xfer(input logic b, output logic r);
    repeat (8) @(negedge pclk);
    sda_m = b;
    repeat (8) @(negedge pclk);
    scl = 1'b1;
    repeat (8) @(negedge pclk);
    r = bus_if.sda_i;
    repeat (8) @(negedge pclk);
    scl = 1'b0;
  endtask

  task automatic do_start();
    repeat (8) @(negedge pclk);
    sda_m = 1'b1;
    repeat (8) @(negedge pclk);
    scl = 1'b1;
    repeat (8) @(negedge pclk);
    sda_m = 1'b0;
    repeat (8) @(negedge pclk);
    scl = 1'b0;
  endtask

  task automatic do_stop();
    repeat (8) @(negedge pclk);
    sda_m = 1'b0;
    repeat (8) @(negedge pclk);
    scl = 1'b1;
    repeat (8) @(negedge pclk);
    sda_m = 1'b1;
    repeat (16) @(negedge pclk);
  endtask

  task automatic send_byte(input logic [7:0] v, output logic ack);
    logic r;
    for (int i = 7; i >= 0; i--) bit_xfer(v[i], r);
    bit_xfer(1'b1, ack);
  endtask

  task automatic recv_byte(input logic mack, output logic [7:0] v);
    logic r;
    for (int i = 7; i >= 0; i--) begin
      bit_xfer(1'b1, r);
      v[i] = r;
    end
    bit_xfer(mack, r);
  endtask

  task automatic end_frame(input logic [6:0] a);
    do_stop();
    if (a != SA) push_obs("quiet", quiet_hits);
    quiet = 1'b0;
    push_obs("idle_busy", busy);
  endtask

  task automatic do_write(input logic [6:0] a, input int n,
                          input bit stp);
    logic ack;
    do_start();
    quiet_hits = 0;
    quiet = (a != SA);
    send_byte({a, 1'b0}, ack);
    push_obs("aack", ack);
    if (!ack) begin
      push_obs("busy", busy);
      for (int i = 0; i < n; i++) begin
        send_byte(wbuf[i], ack);
        push_obs("wack", ack);
        if (ack) break;
      end
    end
    if (stp) end_frame(a);
  endtask

  task automatic do_read(input logic [6:0] a, input int n);
    logic       ack;
    logic [7:0] v;
    do_start();
    quiet_hits = 0;
    quiet = (a != SA);
    send_byte({a, 1'b1}, ack);
    push_obs("aack", ack);
    if (!ack) begin
      push_obs("busy", busy);
      for (int i = 0; i < n; i++) begin
        recv_byte(i == n - 1, v);
        push_obs("rdata", v);
      end
    end
    end_frame(a);
  endtask

  task automatic wr(input logic [6:0] a, input int n, input bit stp);
    model_write(a, n, stp);
    do_write(a, n, stp);
  endtask

  task automatic rd(input logic [6:0] a, input int n);
    model_read(a, n);
    do_read(a, n);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic       ack;
    logic       r;
    logic [6:0] a;
    int         n;
    mdl_reg = 32'h0;
    repeat (3) @(negedge pclk);
    check("rst_reg_q", reg_q, 0);
    check("rst_sda_oe", bus_if.sda_oe, 0);
    check("rst_busy", busy, 0);
    check("rst_wr_done", wr_done, 0);
    check("rst_rd_done", rd_done, 0);
    areset_n = 1'b1;
    repeat (4) @(negedge pclk);

    {wbuf[0], wbuf[1], wbuf[2], wbuf[3]} = 32'hDEAD_BEEF;
    wr(SA, 4, 1'b1);
    rd(SA, 4);
    wr(7'h6C, 4, 1'b1);
    rd(7'h6C, 2);

    {wbuf[0], wbuf[1]} = 16'h1234;
    wr(SA, 2, 1'b0);
    rd(SA, 4);

    {wbuf[0], wbuf[1], wbuf[2], wbuf[3], wbuf[4]} = 40'h11_2233_4455;
    wr(SA, 5, 1'b1);
    rd(SA, 6);

    // Reset in the middle of data byte 2.
    push_exp("aack", 0);
    push_exp("busy", 1);
    push_exp("wack", 0);
    do_start();
    send_byte({SA, 1'b0}, ack);
    push_obs("aack", ack);
    push_obs("busy", busy);
    send_byte(8'hDE, ack);
    push_obs("wack", ack);
    for (int i = 0; i < 4; i++) bit_xfer(i[0], r);
    @(negedge pclk);
    areset_n = 1'b0;
    #1;
    check("mid_rst_reg_q", reg_q, 0);
    check("mid_rst_sda_oe", bus_if.sda_oe, 0);
    check("mid_rst_busy", busy, 0);
    @(negedge pclk);
    areset_n = 1'b1;
    mdl_reg = 32'h0;
    do_stop();
    for (int i = 0; i < 4; i++) wbuf[i] = 8'($urandom);
    wr(SA, 4, 1'b1);
    rd(SA, 4);

    for (int t = 0; t < 14; t++) begin
      a = ($urandom_range(0, 3) == 0) ? 7'($urandom) : SA;
      if ($urandom_range(0, 1) == 0) begin
        n = $urandom_range(1, 6);
        for (int i = 0; i < 6; i++) wbuf[i] = 8'($urandom);
        wr(a, n, 1'b1);
      end else begin
        rd(a, $urandom_range(1, 9));
      end
    end

    repeat (8) @(negedge pclk);
    check("exp_q_empty", exp_q.size(), 0);
    check("obs_q_empty", obs_q.size(), 0);
    check("exp_wr_empty", exp_wr.size(), 0);
    check("wr_done_count", wr_seen, wr_exp);
    check("rd_done_count", rd_seen, rd_exp);
    check("final_reg_q", reg_q, mdl_reg);
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
